icache_dm_param: RTL
====================

# icache_dm_param

Parametrised direct-mapped instruction cache between the CPU fetch stage and the block-wide instruction memory. Generalises the fixed 8-line, 16-byte-block instruction cache to configurable set count, block size and address width. Adds latched miss requests, a whole-cache flush and saturating hit/miss counters.

## Interface
- `ADDR_W`, 10: byte-address bits of `pc` used; higher `pc` bits are ignored.
- `SETS`, 8: number of lines; power of two, at least 2.
- `WORDS_PER_BLOCK`, 4: 32-bit words per line; power of two, at least 2.
- Derived widths:
  - `OFF_W = log2(WORDS_PER_BLOCK)`, `IDX_W = log2(SETS)`.
  - `TAG_W = ADDR_W - 2 - IDX_W - OFF_W`.
  - `BLK_W = 32*WORDS_PER_BLOCK`, `MADDR_W = TAG_W + IDX_W`.
- `clock`  in  1: the only clock; all state changes on posedge.
- `reset`  in  1: synchronous, active-high.
- `pc`  in  32: fetch byte address; bits [1:0] are ignored.
- `flush`  in  1: one-cycle request to invalidate every line.
- `busywait`  out  1: high means `instruction` is not valid this cycle.
- `instruction`  out  32: fetched word.
- `mem_read`  out  1: block read request.
- `mem_address`  out  `MADDR_W`: block address `{tag, index}`.
- `mem_busywait`  in  1: memory busy.
- `mem_readdata`  in  `BLK_W`: returned block; word 0 is in the LSBs.
- `hit_count`  out  32: saturating hit counter.
- `miss_count`  out  32: saturating miss counter.

## Operation
- `pc` fields:
  - offset = `pc[OFF_W+1:2]`
  - index = `pc[IDX_W+OFF_W+1:OFF_W+2]`
  - tag = `pc[ADDR_W-1:IDX_W+OFF_W+2]`
- Line storage: one valid bit, a `TAG_W` tag and a `BLK_W` data field per line.
- Lookup is combinational: hit = valid[index] && tag matches.
- Output rule:
  - `instruction` = word[offset] of line[index] when (state == IDLE && hit && !reset); otherwise 0.
  - `busywait` = reset || state != IDLE || !hit.
- FSM states:
  - IDLE: on a miss, latch the request tag and index into req registers; next state MEM_READ.
  - MEM_READ: `mem_read` = 1 and `mem_address` = `{req_tag, req_idx}`, both held constant.
    - At a posedge with `mem_busywait` == 0: write `mem_readdata`, req_tag and valid = 1 into line[req_idx]; next state IDLE.
    - Otherwise remain in MEM_READ.
- In IDLE, `mem_read` = 0 and `mem_address` = 0.
- A `pc` change during MEM_READ does not disturb the outstanding fill. After returning to IDLE, the current `pc` is looked up again.
- Flush:
  - In IDLE: all valid bits are cleared at that edge. A lookup in that same cycle still counts.
  - In MEM_READ: the request sets `flush_pend`. On the fill edge the line is written, then all valid bits, including the new line, are cleared and `flush_pend` is cleared.
  - Further flushes while `flush_pend` is set are absorbed.
- Counters:
  - `hit_count` increments at each posedge with state == IDLE && hit && !reset.
  - `miss_count` increments on each IDLE to MEM_READ transition.
  - Both saturate at 32'hFFFF_FFFF.
  - Both are cleared only by reset, not by flush.
- Reset:
  - State goes to IDLE, all valid bits and `flush_pend` clear, both counters go to 0. Data and tag arrays are not cleared.
  - Output values: `busywait`=1, `instruction`=0, `mem_read`=0, `mem_address`=0.
- Reset in MEM_READ abandons the fill with no line write. `mem_read` is 0 from the next cycle.

## Timing
- Hit: zero-cycle latency; `instruction` is valid in the same cycle `pc` is presented.
- Miss, with memory holding `mem_busywait` high for N posedges of MEM_READ:
  - cycle 0: IDLE, miss detected.
  - cycles 1..N+1: MEM_READ.
  - cycle N+2: IDLE, hit.
  - `busywait` is high for N+2 cycles.
- Memory contract: `mem_busywait` is high from the cycle `mem_read` rises until data is ready. `mem_readdata` must be valid in the cycle `mem_busywait` is low.
- Only one outstanding request. No speculative or back-to-back memory requests.

## Structure
- Package `icache_pkg`:
  - state enum `{IDLE, MEM_READ}`.
  - `clog2`-based width helper functions for `OFF_W`, `IDX_W`, `TAG_W`.
  - `COUNTER_W = 32`.
- Sub-module `icache_line_store`: holds the valid, tag and data arrays.
  - One combinational read port.
  - One synchronous write port.
  - A synchronous flush-all input.
  - Instantiated once. The FSM, req registers and counters live in the top.

## Test plan
- Reset, then `pc`=0x000: `busywait`=1, `mem_read`=1 and `mem_address`=0 one cycle later. With N=3, the word from `mem_readdata[31:0]` appears at cycle 5 with `busywait`=0. `miss_count`=1.
- Fill block 0x04 with distinct words, then step `pc` 0x040, 0x044, 0x048, 0x04C: four zero-latency hits returning words 0..3. `hit_count` rises by 4 and `mem_read` stays 0.
- Conflict: `pc`=0x010 then `pc`=0x090 (same index, tag 0 vs 1): the second access misses with `mem_address`=0x09, then 0x010 misses again. `miss_count`=3.
- `pc` changed to 0x200 mid-MEM_READ of 0x010: `mem_address` stays 0x01 and line 1 gets tag 0. 0x200 then misses with `mem_address`=0x20.
- `flush` asserted during MEM_READ: after the fill, the same `pc` misses again. `flush` in IDLE on a warm cache: the next access to any line misses.
- Reset asserted in MEM_READ: `mem_read`=0 the next cycle, no line becomes valid, counters read 0. Separately, force both counters to 32'hFFFF_FFFF and confirm they do not wrap.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the parametrised direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_READ = 1'b1
  } state_e;

  localparam int COUNTER_W = 32;

  // Word-offset field width inside a block.
  function automatic int off_w(input int words_per_block);
    return $clog2(words_per_block);
  endfunction

  // Set-index field width.
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Tag width: byte address minus byte offset, index and word offset.
  function automatic int tag_w(input int addr_w, input int sets, input int words_per_block);
    return addr_w - 2 - $clog2(sets) - $clog2(words_per_block);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays for the cache lines: one combinational read port,
// one synchronous write port and a synchronous invalidate-all.
module icache_line_store #(
  parameter int SETS  = 8,
  parameter int IDX_W = 3,
  parameter int TAG_W = 3,
  parameter int BLK_W = 128
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [BLK_W-1:0] rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [BLK_W-1:0] wr_data,
  input  logic             flush_all
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [BLK_W-1:0] data_q [SETS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  // Valid bits: fill sets one line, flush-all wins over a same-edge fill.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (wr_en)     valid_q[wr_idx] <= 1'b1;
      if (flush_all) valid_q         <= '0;
    end
  end

  // Tag and data storage written on a fill.
  // NOTE: these arrays are intentionally not reset; the valid bit alone qualifies them.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_dm_param.sv
// Parametrised direct-mapped instruction cache: combinational hit path,
// single outstanding block fill, deferred flush and saturating hit/miss counters.
module icache_dm_param
  import icache_pkg::*;
#(
  parameter int  ADDR_W          = 10,
  parameter int  SETS            = 8,
  parameter int  WORDS_PER_BLOCK = 4,
  localparam int OFF_W           = off_w(WORDS_PER_BLOCK),
  localparam int IDX_W           = idx_w(SETS),
  localparam int TAG_W           = tag_w(ADDR_W, SETS, WORDS_PER_BLOCK),
  localparam int BLK_W           = 32 * WORDS_PER_BLOCK,
  localparam int MADDR_W         = TAG_W + IDX_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          pc,
  input  logic                 flush,
  output logic                 busywait,
  output logic [31:0]          instruction,
  output logic                 mem_read,
  output logic [MADDR_W-1:0]   mem_address,
  input  logic                 mem_busywait,
  input  logic [BLK_W-1:0]     mem_readdata,
  output logic [COUNTER_W-1:0] hit_count,
  output logic [COUNTER_W-1:0] miss_count
);

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic             unused_pc_bits;

  assign pc_off         = pc[OFF_W+1:2];
  assign pc_idx         = pc[IDX_W+OFF_W+1:OFF_W+2];
  assign pc_tag         = pc[ADDR_W-1:IDX_W+OFF_W+2];
  assign unused_pc_bits = ^{pc[31:ADDR_W], pc[1:0]};

  state_e               state_q, state_d;
  logic [TAG_W-1:0]     req_tag_q, req_tag_d;
  logic [IDX_W-1:0]     req_idx_q, req_idx_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [COUNTER_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [COUNTER_W-1:0] miss_cnt_q, miss_cnt_d;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [BLK_W-1:0] rd_data;
  logic             hit, hit_now, miss_start, fill, flush_all;

  icache_line_store #(
    .SETS (SETS),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W),
    .BLK_W(BLK_W)
  ) u_store (
    .clock    (clock),
    .reset    (reset),
    .rd_idx   (pc_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill),
    .wr_idx   (req_idx_q),
    .wr_tag   (req_tag_q),
    .wr_data  (mem_readdata),
    .flush_all(flush_all)
  );

  assign hit        = rd_valid && (rd_tag == pc_tag);
  assign hit_now    = (state_q == IDLE) && hit && !reset;
  assign miss_start = (state_q == IDLE) && !hit && !reset;
  assign fill       = (state_q == MEM_READ) && !mem_busywait && !reset;
  // A flush seen during a fill is applied after that fill lands, so the new line is dropped too.
  assign flush_all  = !reset && (((state_q == IDLE) && flush) ||
                                 (fill && (flush_pend_q || flush)));

  assign instruction = hit_now ? rd_data[32*pc_off +: 32] : 32'd0;
  assign busywait    = !hit_now;
  assign mem_read    = (state_q == MEM_READ);
  assign mem_address = mem_read ? {req_tag_q, req_idx_q} : '0;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

  // Next-state logic for the FSM, request latch, pending flush and counters.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    req_tag_d    = req_tag_q;
    req_idx_d    = req_idx_q;
    flush_pend_d = flush_pend_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    if (miss_start) begin
      state_d   = MEM_READ;
      req_tag_d = pc_tag;
      req_idx_d = pc_idx;
    end

    if (fill) begin
      state_d      = IDLE;
      flush_pend_d = 1'b0;
    end else if ((state_q == MEM_READ) && flush) begin
      flush_pend_d = 1'b1;
    end

    if (hit_now && (hit_cnt_q != '1))     hit_cnt_d  = hit_cnt_q + 1'b1;
    if (miss_start && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 1'b1;
  end

  // Register update with synchronous reset; a reset mid-fill abandons the request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_tag_q    <= req_tag_d;
      req_idx_q    <= req_idx_d;
      flush_pend_q <= flush_pend_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

endmodule
